// File: rtl/sprite_position_latch_pkg.sv
// sprite_position_latch_pkg: I/O window offsets and CTRL bit positions shared with nano8 assembly defines.
package sprite_position_latch_pkg;
  localparam logic [7:0] DEFAULT_BASE_ADDR = 8'h48;
  localparam int CTRL_HOLD_BIT = 7;
  function automatic logic [7:0] x_off(int i);
    return 8'(2 * i);
  endfunction
  function automatic logic [7:0] y_off(int i);
    return 8'(2 * i + 1);
  endfunction
  function automatic logic [7:0] ctrl_off(int n);
    return 8'(2 * n);
  endfunction
  function automatic logic [7:0] status_off(int n);
    return 8'(2 * n + 1);
  endfunction
endpackage

// File: rtl/sprite_slot.sv
// sprite_slot: shadow/active position and enable for one sprite, with start comparators.
module sprite_slot (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_wr_x,
  input  logic       i_wr_y,
  input  logic       i_wr_en,
  input  logic [7:0] i_data,
  input  logic       i_en,
  input  logic       i_commit,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  output logic [7:0] o_sh_x,
  output logic [7:0] o_sh_y,
  output logic       o_sh_en,
  output logic       o_vstart,
  output logic       o_hstart
);
  logic [7:0] r_sh_x, r_sh_y, r_x, r_y;
  logic       r_sh_en, r_en;
  // commit copies the pre-write shadow, so a same-cycle write waits for the next vsync
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_x  <= '0;
      r_sh_y  <= '0;
      r_sh_en <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_en    <= 1'b0;
    end else begin
      if (i_wr_x) r_sh_x <= i_data;
      if (i_wr_y) r_sh_y <= i_data;
      if (i_wr_en) r_sh_en <= i_en;
      if (i_commit) begin
        r_x  <= r_sh_x;
        r_y  <= r_sh_y;
        r_en <= r_sh_en;
      end
    end
  end
  assign o_sh_x   = r_sh_x;
  assign o_sh_y   = r_sh_y;
  assign o_sh_en  = r_sh_en;
  assign o_vstart = r_en && ({1'b0, r_y} == vpos);
  assign o_hstart = r_en && ({1'b0, r_x} == hpos);
endmodule

// File: rtl/sprite_position_latch.sv
// sprite_position_latch: CPU-mapped double-buffered sprite positions committed on vsync rise.
module sprite_position_latch
  import sprite_position_latch_pkg::*;
#(
  parameter int         NUM_SPRITES  = 4,
  parameter logic [7:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int         LOAD_HPOS    = 256,
  parameter int         LOAD_SPACING = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8:0]             hpos,
  input  logic [8:0]             vpos,
  input  logic                   vsync,
  input  logic [7:0]             address_bus,
  input  logic [7:0]             from_cpu,
  input  logic                   write_enable,
  output logic [7:0]             rd_data,
  output logic                   rd_hit,
  output logic [NUM_SPRITES-1:0] vstart,
  output logic [NUM_SPRITES-1:0] hstart,
  output logic [NUM_SPRITES-1:0] load,
  output logic [7:0]             frame_count
);
  localparam logic [7:0] LAST = BASE_ADDR + status_off(NUM_SPRITES);
  logic                   r_vsync_q, r_hold;
  logic [7:0]             r_fc;
  logic [7:0]             w_off, w_rd, w_ctrl;
  logic                   w_wr, w_commit, w_wr_ctrl;
  logic [7:0]             w_sh_x [NUM_SPRITES];
  logic [7:0]             w_sh_y [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] w_sh_en;
  assign w_off     = address_bus - BASE_ADDR;
  assign rd_hit    = (address_bus >= BASE_ADDR) && (address_bus <= LAST);
  assign w_wr      = write_enable && rd_hit;
  assign w_wr_ctrl = w_wr && (w_off == ctrl_off(NUM_SPRITES));
  assign w_commit  = vsync && !r_vsync_q;
  assign w_ctrl    = {r_hold, 7'(w_sh_en)};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vsync_q <= 1'b0;
      r_hold    <= 1'b0;
      r_fc      <= '0;
    end else begin
      r_vsync_q <= vsync;
      if (w_wr_ctrl) r_hold <= from_cpu[CTRL_HOLD_BIT];
      if (w_commit) r_fc <= r_fc + 8'd1;
    end
  end
  assign frame_count = r_fc;
  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_slot
    sprite_slot u_slot (
      .clk      (clk),
      .reset    (reset),
      .i_wr_x   (w_wr && (w_off == x_off(i))),
      .i_wr_y   (w_wr && (w_off == y_off(i))),
      .i_wr_en  (w_wr_ctrl),
      .i_data   (from_cpu),
      .i_en     (from_cpu[i]),
      .i_commit (w_commit && !r_hold),
      .hpos     (hpos),
      .vpos     (vpos),
      .o_sh_x   (w_sh_x[i]),
      .o_sh_y   (w_sh_y[i]),
      .o_sh_en  (w_sh_en[i]),
      .o_vstart (vstart[i]),
      .o_hstart (hstart[i])
    );
  end
  always_comb begin
    w_rd = (w_off == ctrl_off(NUM_SPRITES)) ? w_ctrl :
           (w_off == status_off(NUM_SPRITES)) ? r_fc : 8'h00;
    for (int k = 0; k < NUM_SPRITES; k++) begin
      if (w_off == x_off(k)) w_rd = w_sh_x[k];
      if (w_off == y_off(k)) w_rd = w_sh_y[k];
    end
  end
  assign rd_data = rd_hit ? w_rd : 8'h00;
  // evaluated at full int width so targets beyond the 9-bit hpos range never alias
  always_comb begin
    load = '0;
    for (int k = 0; k < NUM_SPRITES; k++)
      load[k] = int'(hpos) == LOAD_HPOS + k * LOAD_SPACING;
  end
endmodule

// File: tb/tb_sprite_position_latch.sv
// tb_sprite_position_latch: directed checks of decode, commit, HOLD, same-cycle write, wrap and reset.
module tb_sprite_position_latch;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] hpos = '0, vpos = '0;
  logic       vsync = 1'b0;
  logic [7:0] address_bus = '0, from_cpu = '0;
  logic       write_enable = 1'b0;
  logic [7:0] rd_data, frame_count;
  logic       rd_hit;
  logic [3:0] vstart, hstart, load;
  int checks = 0, failures = 0;

  sprite_position_latch dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .vsync(vsync),
    .address_bus(address_bus), .from_cpu(from_cpu), .write_enable(write_enable),
    .rd_data(rd_data), .rd_hit(rd_hit), .vstart(vstart), .hstart(hstart),
    .load(load), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    address_bus = a;
    from_cpu = d;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    address_bus = a;
    #1;
  endtask

  task automatic pulse();
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_fc", frame_count, 0);
    chk("rst_vstart", vstart, 0);
    chk("rst_hstart", hstart, 0);
    rd(8'h48);
    chk("rst_hit", rd_hit, 1);
    chk("rst_rd", rd_data, 0);
    hpos = 9'd260;
    #1 chk("load1_260", load, 4'b0010);
    hpos = 9'd256;
    #1 chk("load0_256", load, 4'b0001);
    hpos = 9'd268;
    #1 chk("load3_268", load, 4'b1000);
    hpos = 9'd257;
    #1 chk("load_none", load, 4'b0000);

    vpos = 9'd50;
    hpos = 9'd100;
    wr(8'h4A, 8'd100);
    wr(8'h4B, 8'd50);
    wr(8'h50, 8'h02);
    rd(8'h4A);
    chk("rd_x1", rd_data, 100);
    rd(8'h50);
    chk("rd_ctrl", rd_data, 8'h02);
    chk("pre_vstart", vstart, 0);
    chk("pre_hstart", hstart, 0);
    pulse();
    chk("fc1", frame_count, 1);
    chk("vstart1", vstart, 4'b0010);
    chk("hstart1", hstart, 4'b0010);
    vpos = 9'd51;
    hpos = 9'd101;
    #1 chk("vstart_off", vstart, 0);
    chk("hstart_off", hstart, 0);
    hpos = 9'd356;
    #1 chk("hstart_zext", hstart, 0);

    vpos = 9'd50;
    wr(8'h50, 8'h82);
    wr(8'h4A, 8'd20);
    pulse();
    pulse();
    chk("hold_fc", frame_count, 3);
    hpos = 9'd100;
    #1 chk("hold_x_old", hstart, 4'b0010);
    hpos = 9'd20;
    #1 chk("hold_x_new", hstart, 0);
    rd(8'h50);
    chk("rd_ctrl_hold", rd_data, 8'h82);
    wr(8'h50, 8'h02);
    pulse();
    chk("unhold_fc", frame_count, 4);
    chk("unhold_x", hstart, 4'b0010);

    wr(8'h50, 8'h03);
    address_bus = 8'h48;
    from_cpu = 8'd7;
    write_enable = 1'b1;
    vsync = 1'b1;
    tick();
    write_enable = 1'b0;
    chk("same_rd", rd_data, 7);
    hpos = 9'd0;
    #1 chk("same_x0_old", hstart, 4'b0001);
    hpos = 9'd7;
    #1 chk("same_x0_not7", hstart, 0);
    vsync = 1'b0;
    tick();
    pulse();
    chk("same_x0_new", hstart, 4'b0001);
    chk("fc6", frame_count, 6);
    rd(8'h51);
    chk("rd_status", rd_data, 6);
    wr(8'h51, 8'h55);
    chk("status_ro", rd_data, 6);

    for (int n = 0; n < 250; n++) pulse();
    rd(8'h51);
    chk("wrap", rd_data, 0);
    rd(8'h47);
    chk("below_hit", rd_hit, 0);
    chk("below_rd", rd_data, 0);
    rd(8'h52);
    chk("above_hit", rd_hit, 0);

    hpos = 9'd20;
    #1 chk("pre_rst_v", vstart, 4'b0010);
    chk("pre_rst_h", hstart, 4'b0010);
    reset = 1'b1;
    vsync = 1'b1;
    tick();
    reset = 1'b0;
    vsync = 1'b0;
    chk("mid_rst_v", vstart, 0);
    chk("mid_rst_h", hstart, 0);
    chk("mid_rst_fc", frame_count, 0);
    rd(8'h4A);
    chk("mid_rst_rd", rd_data, 0);
    tick();
    wr(8'h4A, 8'd100);
    wr(8'h4B, 8'd50);
    wr(8'h50, 8'h02);
    pulse();
    hpos = 9'd100;
    #1 chk("recommit_h", hstart, 4'b0010);
    chk("recommit_v", vstart, 4'b0010);
    chk("recommit_fc", frame_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
